// File: rtl/ps2_kbd_ctrl.sv
// PS/2 keyboard sequencing controller.
// Assembles E0/F0 prefixed scan-code sequences into single key events,
// tracks the held key and a press counter, and drives four registered
// active-low seven-segment digits. A stalled prefix sequence is
// abandoned after TIMEOUT_CYC idle cycles.
module ps2_kbd_ctrl #(
  parameter int TIMEOUT_CYC = 1000000,
  parameter int CNT_W       = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             rx_valid,
  input  logic [7:0]       rx_data,
  output logic             rx_ready,
  output logic             ev_valid,
  output logic [7:0]       ev_code,
  output logic             ev_ext,
  output logic             ev_break,
  input  logic             ev_ready,
  output logic             key_down,
  output logic [7:0]       cur_code,
  output logic             cur_ext,
  output logic [CNT_W-1:0] press_cnt,
  output logic             err_timeout,
  output logic [7:0]       seg_code_hi,
  output logic [7:0]       seg_code_lo,
  output logic [7:0]       seg_cnt_hi,
  output logic [7:0]       seg_cnt_lo
);

  localparam int TO_W = $clog2(TIMEOUT_CYC + 1);
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYC - 1);

  localparam logic [7:0] B_EXT = 8'hE0;
  localparam logic [7:0] B_BRK = 8'hF0;

  typedef enum logic [1:0] {
    S_IDLE,
    S_EXT,
    S_BRK,
    S_EXT_BRK
  } state_t;

  state_t            state_q, state_d;
  logic [TO_W-1:0]   to_cnt_q, to_cnt_d;
  logic              ev_valid_q, ev_valid_d;
  logic [7:0]        ev_code_q, ev_code_d;
  logic              ev_ext_q, ev_ext_d;
  logic              ev_break_q, ev_break_d;
  logic              key_down_q, key_down_d;
  logic [7:0]        cur_code_q, cur_code_d;
  logic              cur_ext_q, cur_ext_d;
  logic [CNT_W-1:0]  press_cnt_q, press_cnt_d;
  logic [7:0]        seg_code_hi_q, seg_code_hi_d;
  logic [7:0]        seg_code_lo_q, seg_code_lo_d;
  logic [7:0]        seg_cnt_hi_q, seg_cnt_hi_d;
  logic [7:0]        seg_cnt_lo_q, seg_cnt_lo_d;

  logic              accept;
  logic              is_prefix;
  logic              is_drop;
  logic              gen;
  logic              gen_ext;
  logic              gen_brk;
  logic              timeout;
  logic [7:0]        cnt_disp;

  // Active-low {dp,g,f,e,d,c,b,a} pattern for one hex nibble; dp stays dark.
  function automatic logic [7:0] seg7(input logic [3:0] n);
    logic [7:0] s;
    case (n)
      4'h0: s = 8'hC0;
      4'h1: s = 8'hF9;
      4'h2: s = 8'hA4;
      4'h3: s = 8'hB0;
      4'h4: s = 8'h99;
      4'h5: s = 8'h92;
      4'h6: s = 8'h82;
      4'h7: s = 8'hF8;
      4'h8: s = 8'h80;
      4'h9: s = 8'h90;
      4'hA: s = 8'h88;
      4'hB: s = 8'h83;
      4'hC: s = 8'hC6;
      4'hD: s = 8'hA1;
      4'hE: s = 8'h86;
      default: s = 8'h8E;
    endcase
    return s;
  endfunction

  // The single-entry event buffer frees up in the same cycle it is popped.
  assign rx_ready  = !rst && (!ev_valid_q || ev_ready);
  assign accept    = rx_valid && rx_ready;
  assign is_prefix = (rx_data == B_EXT) || (rx_data == B_BRK);
  assign is_drop   = (rx_data == 8'h00) || (rx_data == 8'hAA) || (rx_data == 8'hEE) ||
                     (rx_data == 8'hFA) || (rx_data == 8'hFE) || (rx_data == 8'hFF);

  // Only the low byte of the press counter is shown; narrow counters are zero-padded.
  generate
    if (CNT_W >= 8) begin : g_cnt_wide
      assign cnt_disp = press_cnt_q[7:0];
    end else begin : g_cnt_narrow
      assign cnt_disp = {{(8 - CNT_W){1'b0}}, press_cnt_q};
    end
  endgenerate

  // Next-state: prefix assembly on accepted bytes, otherwise the stall timeout.
  always_comb begin
    state_d = state_q;
    gen     = 1'b0;
    gen_ext = 1'b0;
    gen_brk = 1'b0;
    timeout = 1'b0;
    if (accept) begin
      case (state_q)
        S_IDLE: begin
          if (rx_data == B_EXT)      state_d = S_EXT;
          else if (rx_data == B_BRK) state_d = S_BRK;
          else if (!is_drop)         gen = 1'b1;
        end
        S_EXT: begin
          if (rx_data == B_BRK) begin
            state_d = S_EXT_BRK;
          end else if (rx_data != B_EXT) begin
            gen     = 1'b1;
            gen_ext = 1'b1;
            state_d = S_IDLE;
          end
        end
        S_BRK: begin
          state_d = S_IDLE;
          gen     = !is_prefix;
          gen_brk = 1'b1;
        end
        default: begin
          state_d = S_IDLE;
          gen     = !is_prefix;
          gen_ext = 1'b1;
          gen_brk = 1'b1;
        end
      endcase
    end else if (state_q != S_IDLE && to_cnt_q == TO_LAST) begin
      state_d = S_IDLE;
      timeout = 1'b1;
    end
  end

  // Stall counter: runs only while a prefix is pending and no byte arrives.
  always_comb begin
    to_cnt_d = to_cnt_q + TO_W'(1);
    if (accept || state_q == S_IDLE || timeout) begin
      to_cnt_d = '0;
    end
  end

  assign err_timeout = timeout && !rst;

  // Event buffer: load on a completed sequence, clear when the consumer pops.
  always_comb begin
    ev_valid_d = ev_valid_q;
    ev_code_d  = ev_code_q;
    ev_ext_d   = ev_ext_q;
    ev_break_d = ev_break_q;
    if (gen) begin
      ev_valid_d = 1'b1;
      ev_code_d  = rx_data;
      ev_ext_d   = gen_ext;
      ev_break_d = gen_brk;
    end else if (ev_valid_q && ev_ready) begin
      ev_valid_d = 1'b0;
    end
  end

  // Held-key tracking: typematic repeats of the held key do not count as presses.
  always_comb begin
    key_down_d  = key_down_q;
    cur_code_d  = cur_code_q;
    cur_ext_d   = cur_ext_q;
    press_cnt_d = press_cnt_q;
    if (gen && !gen_brk) begin
      if (!key_down_q || rx_data != cur_code_q || gen_ext != cur_ext_q) begin
        key_down_d  = 1'b1;
        cur_code_d  = rx_data;
        cur_ext_d   = gen_ext;
        press_cnt_d = press_cnt_q + CNT_W'(1);
      end
    end else if (gen && gen_brk) begin
      if (key_down_q && rx_data == cur_code_q && gen_ext == cur_ext_q) begin
        key_down_d = 1'b0;
      end
    end
  end

  // Display digits follow the tracking registers one cycle later.
  always_comb begin
    seg_code_hi_d = key_down_q ? seg7(cur_code_q[7:4]) : 8'hFF;
    seg_code_lo_d = key_down_q ? seg7(cur_code_q[3:0]) : 8'hFF;
    seg_cnt_hi_d  = seg7(cnt_disp[7:4]);
    seg_cnt_lo_d  = seg7(cnt_disp[3:0]);
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= S_IDLE;
      to_cnt_q      <= '0;
      ev_valid_q    <= 1'b0;
      ev_code_q     <= 8'h00;
      ev_ext_q      <= 1'b0;
      ev_break_q    <= 1'b0;
      key_down_q    <= 1'b0;
      cur_code_q    <= 8'h00;
      cur_ext_q     <= 1'b0;
      press_cnt_q   <= '0;
      seg_code_hi_q <= 8'hFF;
      seg_code_lo_q <= 8'hFF;
      seg_cnt_hi_q  <= 8'hC0;
      seg_cnt_lo_q  <= 8'hC0;
    end else begin
      state_q       <= state_d;
      to_cnt_q      <= to_cnt_d;
      ev_valid_q    <= ev_valid_d;
      ev_code_q     <= ev_code_d;
      ev_ext_q      <= ev_ext_d;
      ev_break_q    <= ev_break_d;
      key_down_q    <= key_down_d;
      cur_code_q    <= cur_code_d;
      cur_ext_q     <= cur_ext_d;
      press_cnt_q   <= press_cnt_d;
      seg_code_hi_q <= seg_code_hi_d;
      seg_code_lo_q <= seg_code_lo_d;
      seg_cnt_hi_q  <= seg_cnt_hi_d;
      seg_cnt_lo_q  <= seg_cnt_lo_d;
    end
  end

  assign ev_valid    = ev_valid_q;
  assign ev_code     = ev_code_q;
  assign ev_ext      = ev_ext_q;
  assign ev_break    = ev_break_q;
  assign key_down    = key_down_q;
  assign cur_code    = cur_code_q;
  assign cur_ext     = cur_ext_q;
  assign press_cnt   = press_cnt_q;
  assign seg_code_hi = seg_code_hi_q;
  assign seg_code_lo = seg_code_lo_q;
  assign seg_cnt_hi  = seg_cnt_hi_q;
  assign seg_cnt_lo  = seg_cnt_lo_q;

endmodule

// File: tb/tb_ps2_kbd_ctrl.sv
// Bench for ps2_kbd_ctrl: directed scenarios followed by random byte
// streams, all compared against a prefix-flag reference model.
module tb_ps2_kbd_ctrl;

  localparam int TO = 16;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       rx_valid = 1'b0;
  logic [7:0] rx_data = 8'h00;
  logic       rx_ready;
  logic       ev_valid;
  logic [7:0] ev_code;
  logic       ev_ext;
  logic       ev_break;
  logic       ev_ready = 1'b1;
  logic       key_down;
  logic [7:0] cur_code;
  logic       cur_ext;
  logic [7:0] press_cnt;
  logic       err_timeout;
  logic [7:0] seg_code_hi, seg_code_lo, seg_cnt_hi, seg_cnt_lo;

  ps2_kbd_ctrl #(.TIMEOUT_CYC(TO), .CNT_W(8)) dut (
    .clk(clk), .rst(rst),
    .rx_valid(rx_valid), .rx_data(rx_data), .rx_ready(rx_ready),
    .ev_valid(ev_valid), .ev_code(ev_code), .ev_ext(ev_ext), .ev_break(ev_break),
    .ev_ready(ev_ready),
    .key_down(key_down), .cur_code(cur_code), .cur_ext(cur_ext),
    .press_cnt(press_cnt), .err_timeout(err_timeout),
    .seg_code_hi(seg_code_hi), .seg_code_lo(seg_code_lo),
    .seg_cnt_hi(seg_cnt_hi), .seg_cnt_lo(seg_cnt_lo)
  );

  always #5 clk = ~clk;

  int    checks = 0;
  int    errors = 0;
  string step = "init";

  // Reference model: pending-prefix flags, held key, press count, event buffer.
  bit         m_ext, m_brk;
  bit         m_kd, m_cext;
  logic [7:0] m_code, m_cnt;
  bit         m_ev_v, m_ev_ext, m_ev_brk;
  logic [7:0] m_ev_code;

  logic [7:0] seg_tab [16] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
                               8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E};
  logic [7:0] codes [4] = '{8'h1C, 8'h32, 8'h75, 8'h6B};
  logic [7:0] drops [6] = '{8'h00, 8'hAA, 8'hEE, 8'hFA, 8'hFE, 8'hFF};

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s/%s observed=%0h expected=%0h", step, tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_ext = 0; m_brk = 0; m_kd = 0; m_cext = 0; m_code = 8'h00; m_cnt = 8'h00;
    m_ev_v = 0; m_ev_ext = 0; m_ev_brk = 0; m_ev_code = 8'h00;
  endtask

  // Expected {code_hi, code_lo, cnt_hi, cnt_lo} from the model's tracking state.
  function automatic logic [31:0] seg_now();
    logic [7:0] h, l;
    h = m_kd ? seg_tab[m_code[7:4]] : 8'hFF;
    l = m_kd ? seg_tab[m_code[3:0]] : 8'hFF;
    return {h, l, seg_tab[m_cnt[7:4]], seg_tab[m_cnt[3:0]]};
  endfunction

  // Apply one byte to the prefix flags; report whether it completes an event.
  task automatic model_byte(input logic [7:0] b, output bit gen, output bit ext, output bit brk);
    bit pre;
    pre = (b == 8'hE0) || (b == 8'hF0);
    gen = 0; ext = 0; brk = 0;
    if (m_brk) begin
      ext = m_ext; brk = 1; gen = !pre;
      m_brk = 0; m_ext = 0;
    end else if (m_ext) begin
      if (b == 8'hF0) m_brk = 1;
      else if (b != 8'hE0) begin gen = 1; ext = 1; m_ext = 0; end
    end else begin
      if (b == 8'hE0) m_ext = 1;
      else if (b == 8'hF0) m_brk = 1;
      else if (!(b inside {8'h00, 8'hAA, 8'hEE, 8'hFA, 8'hFE, 8'hFF})) gen = 1;
    end
  endtask

  task automatic model_track(input logic [7:0] c, input bit ext, input bit brk);
    if (!brk) begin
      if (!m_kd || c != m_code || ext != m_cext) begin
        m_kd = 1; m_code = c; m_cext = ext; m_cnt = m_cnt + 8'd1;
      end
    end else if (m_kd && c == m_code && ext == m_cext) begin
      m_kd = 0;
    end
  endtask

  task automatic check_all(input logic [31:0] segs);
    chk("ev_valid", ev_valid, m_ev_v);
    if (m_ev_v) begin
      chk("ev_code", ev_code, m_ev_code);
      chk("ev_ext", ev_ext, m_ev_ext);
      chk("ev_break", ev_break, m_ev_brk);
    end
    chk("key_down", key_down, m_kd);
    chk("cur_code", cur_code, m_code);
    chk("cur_ext", cur_ext, m_cext);
    chk("press_cnt", press_cnt, m_cnt);
    chk("err_timeout", err_timeout, 0);
    chk("rx_ready", rx_ready, !m_ev_v || ev_ready);
    chk("segs", {seg_code_hi, seg_code_lo, seg_cnt_hi, seg_cnt_lo}, segs);
  endtask

  // Called just after a falling edge: put a byte on the bus.
  task automatic present(input logic [7:0] b);
    rx_valid = 1'b1;
    rx_data  = b;
    #1;
    chk("rx_ready_present", rx_ready, !m_ev_v || ev_ready);
    chk("err_timeout_present", err_timeout, 0);
  endtask

  // Let the presented byte be taken, then check at N+1 and N+2.
  task automatic complete();
    logic [31:0] old_segs;
    logic [7:0]  b;
    bit          pop, gen, ext, brk;
    old_segs = seg_now();
    pop = m_ev_v && ev_ready;
    b = rx_data;
    @(posedge clk);
    model_byte(b, gen, ext, brk);
    if (gen) begin
      m_ev_v = 1; m_ev_code = b; m_ev_ext = ext; m_ev_brk = brk;
      model_track(b, ext, brk);
    end else if (pop) begin
      m_ev_v = 0;
    end
    @(negedge clk);
    rx_valid = 1'b0;
    #1;
    check_all(old_segs);
    pop = m_ev_v && ev_ready;
    @(posedge clk);
    if (pop) m_ev_v = 0;
    @(negedge clk);
    #1;
    check_all(seg_now());
    $display("byte %02h gen=%0d ext=%0d brk=%0d key_down=%0d cur=%02h cnt=%0d",
             b, gen, ext, brk, m_kd, m_code, m_cnt);
  endtask

  task automatic send(input logic [7:0] b);
    present(b);
    complete();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    rx_valid = 1'b0;
    @(posedge clk);
    @(negedge clk);
    #1;
    model_reset();
    chk("rst_rx_ready", rx_ready, 0);
    chk("rst_ev_valid", ev_valid, 0);
    chk("rst_ev_fields", {ev_code, ev_ext, ev_break}, 0);
    chk("rst_track", {key_down, cur_code, cur_ext, press_cnt}, 0);
    chk("rst_err", err_timeout, 0);
    chk("rst_segs", {seg_code_hi, seg_code_lo, seg_cnt_hi, seg_cnt_lo}, 32'hFFFF_C0C0);
    rst = 1'b0;
    #1;
    chk("rst_release_rx_ready", rx_ready, 1);
    $display("reset applied");
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] b;
    model_reset();
    @(posedge clk);
    step = "reset";
    do_reset();

    // Single make.
    step = "make_1c";
    send(8'h1C);
    chk("cnt_after_1c", press_cnt, 8'd1);
    chk("seg_hi_1c", seg_code_hi, 8'hF9);
    chk("seg_lo_1c", seg_code_lo, 8'hC6);
    chk("segcnt_lo_1c", seg_cnt_lo, 8'hF9);

    // Typematic repeats then release.
    step = "typematic";
    repeat (4) send(8'h1C);
    send(8'hF0);
    send(8'h1C);
    chk("cnt_typematic", press_cnt, 8'd1);
    chk("seg_blank", {seg_code_hi, seg_code_lo}, 16'hFFFF);

    // Extended make and break, then a doubled break prefix.
    step = "extended";
    send(8'hE0); send(8'h75);
    send(8'hE0); send(8'hF0); send(8'h75);
    chk("cur_ext_75", cur_ext, 1);
    chk("key_up_75", key_down, 0);
    send(8'h1C); send(8'hF0); send(8'hF0);
    send(8'h32);
    chk("after_ff_break_flag", ev_break, 0);

    // Back-pressure: the second byte waits until the first event is taken.
    step = "backpressure";
    ev_ready = 1'b0;
    send(8'h1C);
    present(8'h32);
    repeat (3) begin
      @(negedge clk);
      #1;
      chk("bp_rx_ready", rx_ready, 0);
      chk("bp_hold_code", {ev_valid, ev_code}, {1'b1, 8'h1C});
    end
    ev_ready = 1'b1;
    #1;
    chk("bp_release_ready", rx_ready, 1);
    complete();

    // Prefix left hanging: timeout fires in the 16th cycle after acceptance.
    step = "timeout";
    send(8'hF0);
    for (int j = 3; j <= TO + 4; j++) begin
      @(negedge clk);
      #1;
      chk($sformatf("err_timeout_c%0d", j), err_timeout, (j == TO));
      if (j == TO) begin m_brk = 0; m_ext = 0; end
    end
    send(8'h1C);
    chk("post_timeout_make", ev_break, 0);

    // A byte arriving in the expiry cycle wins over the timeout.
    step = "byte_wins";
    send(8'hE0);
    for (int j = 3; j < TO; j++) begin
      @(negedge clk);
      #1;
      chk($sformatf("nowin_err_c%0d", j), err_timeout, 0);
    end
    @(negedge clk);
    present(8'h75);
    complete();
    chk("byte_wins_ext", ev_ext, 1);

    // Press counter wrap with alternating new keys.
    step = "wrap";
    for (int i = 0; i < 300 && m_cnt != 8'd255; i++) begin
      send((m_code == 8'h1C && m_kd) ? 8'h32 : 8'h1C);
    end
    chk("cnt_at_255", press_cnt, 8'd255);
    send((m_code == 8'h1C) ? 8'h32 : 8'h1C);
    chk("cnt_wrapped", press_cnt, 8'd0);
    chk("segcnt_wrapped", {seg_cnt_hi, seg_cnt_lo}, 16'hC0C0);

    // Reset drops a pending event and a half-built prefix.
    step = "reset_mid";
    ev_ready = 1'b0;
    send(8'h6B);
    do_reset();
    ev_ready = 1'b1;
    send(8'hE0);
    do_reset();
    send(8'h75);
    chk("after_rst_ext", ev_ext, 0);
    chk("after_rst_cnt", press_cnt, 8'd1);

    // Random streams with occasional consumer stalls.
    step = "random";
    for (int i = 0; i < 300; i++) begin
      int r;
      r = int'($urandom_range(0, 9));
      if (r < 2)       b = 8'hE0;
      else if (r == 2) b = 8'hF0;
      else if (r < 7)  b = codes[$urandom_range(0, 3)];
      else if (r == 7) b = drops[$urandom_range(0, 5)];
      else             b = 8'($urandom_range(0, 255));
      ev_ready = ($urandom_range(0, 3) != 0);
      present(b);
      if (m_ev_v && !ev_ready) begin
        @(negedge clk);
        #1;
        chk("rnd_stall_ready", rx_ready, 0);
        ev_ready = 1'b1;
        #1;
        chk("rnd_release_ready", rx_ready, 1);
      end
      complete();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/ps2_kbd_ctrl.md
Name: ps2_kbd_ctrl

Overview:
- Sequencing controller between the PS/2 byte receiver and the seven-segment / event consumers.
- Consumes raw scan-code bytes over a valid/ready handshake and assembles multi-byte sequences (E0 extended prefix, F0 break prefix) into single key events.
- Tracks the currently held key, counts distinct key presses, and drives four registered seven-segment digits.
- Recovers from truncated prefix sequences with a timeout.

Parameters:
- TIMEOUT_CYC, 1000000: idle cycles allowed in a prefix state before aborting to S_IDLE.
- CNT_W, 8: width of the press counter. Only the low 8 bits are displayed.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous reset, active-high
- rx_valid  in  1  receiver byte valid
- rx_data  in  8  receiver scan-code byte
- rx_ready  out  1  controller accepts a byte this cycle
- ev_valid  out  1  key event available
- ev_code  out  8  event scan code (prefixes stripped)
- ev_ext  out  1  event had E0 prefix
- ev_break  out  1  event is a release
- ev_ready  in  1  consumer takes the event
- key_down  out  1  a key is currently held
- cur_code  out  8  code of the held or last held key
- cur_ext  out  1  ext flag of the held or last held key
- press_cnt  out  CNT_W  count of distinct presses, wraps
- err_timeout  out  1  one-cycle pulse on prefix timeout
- seg_code_hi  out  8  cur_code high nibble, active-low
- seg_code_lo  out  8  cur_code low nibble, active-low
- seg_cnt_hi  out  8  press_cnt[7:4], active-low
- seg_cnt_lo  out  8  press_cnt[3:0], active-low

Behaviour:
- Clock and reset: one clock (clk); reset is synchronous and active-high (rst).
- Reset values:
  - FSM = S_IDLE.
  - ev_valid, ev_code, ev_ext, ev_break = 0.
  - key_down, cur_code, cur_ext = 0; press_cnt = 0; err_timeout = 0.
  - seg_code_* = 0xFF (blank); seg_cnt_* = 0xC0 (shows "00").
- rx_ready (combinational) = !rst && (!ev_valid || ev_ready). A byte is accepted when rx_valid && rx_ready.
- Event buffer: one entry.
  - A byte accepted in cycle N that completes an event sets ev_valid in cycle N+1.
  - ev_* fields are held stable until ev_valid && ev_ready.
  - Simultaneous pop and new event: the new event loads and ev_valid stays 1.
- FSM, evaluated only on an accepted byte:
  - S_IDLE:
    - E0 -> S_EXT.
    - F0 -> S_BRK.
    - 00, AA, EE, FA, FE, FF are dropped, stay S_IDLE.
    - Any other byte -> make event (ext=0) and stay S_IDLE.
  - S_EXT:
    - F0 -> S_EXT_BRK.
    - E0 -> stay S_EXT.
    - Any other byte -> make event (ext=1) -> S_IDLE.
  - S_BRK:
    - E0 or F0 -> S_IDLE, no event (protocol error).
    - Any other byte -> break event (ext=0) -> S_IDLE.
  - S_EXT_BRK:
    - E0 or F0 -> S_IDLE, no event.
    - Any other byte -> break event (ext=1) -> S_IDLE.
- Timeout:
  - A cycle counter clears on every accepted byte and while in S_IDLE.
  - In any other state, when the counter reaches TIMEOUT_CYC-1 the FSM goes to S_IDLE and err_timeout pulses for one cycle.
  - If a byte is accepted in the same cycle the counter expires, the byte wins and no timeout occurs.
- Key tracking: updated in the same cycle as the event is generated, visible at N+1.
  - Make while !key_down, or make whose {ext,code} differs from {cur_ext,cur_code}: key_down=1, cur_* loaded, press_cnt += 1 (modulo 2^CNT_W).
  - Make equal to the held key (typematic repeat): event is still emitted, press_cnt and cur_* are unchanged.
  - Break matching {cur_ext,cur_code} while key_down: key_down=0, cur_* retained.
  - Break not matching: event is emitted, tracking unchanged.
- Seven-segment outputs:
  - Registered from the tracking registers, so they appear at N+2 relative to byte acceptance.
  - Active-low bit order {dp,g,f,e,d,c,b,a}, dp always 1.
  - Nibble encoding 0..F: C0 F9 A4 B0 99 92 82 F8 80 90 88 83 C6 A1 86 8E.
  - seg_code_* = FF when !key_down. seg_cnt_* are always displayed.
- Reset mid-sequence: on the next edge all state returns to reset values, and any partially assembled prefix and any pending event are discarded.

Test Plan:
- Bytes 1C, ev_ready=1 -> one event {1C,ext0,brk0}; key_down=1; press_cnt=1; seg_code_hi=F9, seg_code_lo=C6; seg_cnt_lo=F9.
- 1C x4 (typematic), then F0 1C -> five events; press_cnt stays 1; after the break, key_down=0 and seg_code_hi/lo=FF.
- E0 75 then E0 F0 75 -> events {75,ext1,brk0} and {75,ext1,brk1}; cur_ext=1; key_down ends 0; 1C F0 F0 -> one make, then no event, FSM back to S_IDLE.
- ev_ready=0, send 1C then 32 -> ev_valid=1 holds 1C; rx_ready=0 and the 32 byte is not consumed; raise ev_ready -> 1C pops, 32 accepted next, event {32} follows.
- TIMEOUT_CYC=16, send F0 then silence -> err_timeout pulse exactly 16 cycles after acceptance; then 1C -> make event, not break.
- Drive press_cnt to 255 with alternating codes, then one more new make -> press_cnt=0, seg_cnt_*=C0; assert rst between E0 and 75 -> 75 yields a make with ext=0.
